mcpu_fetch_unit: RTL
====================

# mcpu_fetch_unit

Instruction fetch stage of the MCPU. It sits between `MCPU_RAMController`'s instruction read port and the decode stage. It owns the program counter and drives `instraddr` from it. Each cycle it captures the combinationally returned `instrrd` into a small prefetch FIFO, and presents fetched words with their addresses to decode over a valid/ready handshake. It supports start, halt and branch redirect with flush.

## Interface
- `WORD_SIZE`, 8, instruction word width (matches RAM controller)
- `ADDR_WIDTH`, 8, instruction address width; PC range 0..2^ADDR_WIDTH-1
- `FIFO_DEPTH`, 4, prefetch entries; power of two, >= 2
- `RESET_PC`, 0, PC loaded on `start`
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level, sampled in IDLE; begins fetching at `RESET_PC`
- `halt`  in  1  stop issuing new fetches; FIFO still drains
- `redirect`  in  1  branch/jump taken; flush and refetch
- `redirect_addr`  in  ADDR_WIDTH  target of redirect
- `instraddr`  out  ADDR_WIDTH  to RAM controller; equals PC register
- `instrrd`  in  WORD_SIZE  from RAM controller; valid same cycle (combinational read)
- `instr_out`  out  WORD_SIZE  FIFO head word to decode
- `instr_pc`  out  ADDR_WIDTH  address of `instr_out`
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  decode accepts head this cycle
- `fetching`  out  1  FSM in FETCH

## Operation
- FSM states IDLE, FETCH, HALTED; reset state IDLE.
- IDLE: no pushes. `start` -> FETCH with PC <= `RESET_PC`. `redirect` -> FETCH with PC <= `redirect_addr`. Redirect has priority over start.
- FETCH: push {`instrrd`, PC} and PC <= PC+1 when the push condition holds. Push condition: count < FIFO_DEPTH, or a pop occurs in the same cycle. `halt` -> HALTED; no push in the cycle `halt` is sampled.
- HALTED: no pushes; PC held. `redirect` -> FETCH with PC <= `redirect_addr` and flush. `start` is ignored.
- Pop: `instr_valid && instr_ready` removes the head.
- Redirect in FETCH or HALTED:
  - FIFO cleared (count <= 0), PC <= `redirect_addr`, no push and no pop that cycle.
  - A concurrent `instr_ready` is ignored.
  - Redirect wins over halt.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFF+1 wraps to 0x00 without a flag. Pointers wrap modulo FIFO_DEPTH. The count is clog2(FIFO_DEPTH)+1 bits.
- Full: no push without a concurrent pop; PC holds so no word is skipped. Empty: `instr_valid` = 0, and the head outputs hold their last values.

## Timing
- Reset values: `instraddr` = 0, `instr_out` = 0, `instr_pc` = 0, `instr_valid` = 0, `fetching` = 0. The FIFO is empty.
- Asynchronous reset mid-operation discards all FIFO contents and returns to IDLE immediately.
- Fetch latency:
  - PC = A is driven during cycle N; `instrrd` is sampled at the end of N.
  - {word(A), A} is visible on `instr_out`/`instr_pc` in cycle N+1 if the FIFO was empty.
- `start` sampled at edge E puts the PC at `RESET_PC` from E. The first `instr_valid` is at edge E+1.
- Steady state with `instr_ready` held high: one instruction per cycle.
- Redirect sampled at edge R:
  - `instr_valid` = 0 after R.
  - Word at `redirect_addr` is valid after R+1.
  - Two-cycle bubble at decode.
- `instr_out`/`instr_pc`/`instr_valid` are driven from registers and FIFO storage only; no combinational path from `instr_ready`.

## Structure
- Shared package `mcpu_pkg`: WORD_SIZE and ADDR_WIDTH defaults, and fetch FSM state encoding (IDLE=0, FETCH=1, HALTED=2). The RAM controller and decode stage use the same package.
- One sub-module, `mcpu_fetch_fifo`: synchronous FIFO of {WORD_SIZE+ADDR_WIDTH} entries.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, count, head.
  - Reset: asynchronous active-low.
- The top level holds the FSM, PC and push/pop control.

## Test plan
- Basic fetch: RAM[0..7] = 0x10..0x17; start with `instr_ready` = 1 -> `instr_out` 0x10..0x17 on consecutive cycles, `instr_pc` 0..7, first valid one cycle after start.
- Backpressure: `instr_ready` = 0 for 10 cycles -> exactly 4 entries (PC 0..3), `instraddr` holds at 4. Release -> 0x10,0x11,... in order, none lost or duplicated.
- Redirect with a full FIFO holding PC 0..3, `redirect_addr` = 0x40, RAM[0x40] = 0xAB:
  - `instr_valid` drops the next cycle.
  - Next valid shows 0xAB with `instr_pc` 0x40.
  - Entries 0..3 are never seen by decode.
- Wrap: redirect to 0xFE -> `instr_pc` sequence 0xFE, 0xFF, 0x00, 0x01 with the matching RAM words.
- Halt/drain: halt after 2 fetches while `instr_ready` = 0 -> `fetching` = 0, `instraddr` frozen. Decode then drains exactly the fetched entries, `instr_valid` goes low, and redirect to 0x20 resumes at 0x20.
- Reset mid-stream: assert `rst_n` = 0 with 3 entries buffered -> outputs go to reset values immediately. After release, a start fetches from `RESET_PC` again.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: default bus widths and the fetch FSM encoding.
// The RAM controller and decode stage import the same package.
package mcpu_pkg;

   localparam int DEF_WORD_SIZE  = 8;
   localparam int DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   // Occupancy counter width: one extra bit so "full" is representable.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mcpu_fetch_unit_if.sv
// Fetch-to-decode handshake: head word, its address, valid/ready.
interface mcpu_fetch_unit_if
   import mcpu_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_WORD_SIZE,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic [WORD_SIZE-1:0]  instr_out;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;

   modport master (output instr_out, output instr_pc, output instr_valid, input instr_ready);
   modport slave  (input instr_out, input instr_pc, input instr_valid, output instr_ready);

endinterface

// File: rtl/mcpu_fetch_fifo.sv
// Prefetch FIFO with a registered head: the head register is loaded with the
// entry that will be at the front after this edge, and holds when the FIFO empties.
module mcpu_fetch_fifo
   import mcpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              push_s, pop_s;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == {CNT_W{1'b0}});
   assign count  = count_q;
   assign head   = head_q;
   assign pop_s  = pop & ~empty & ~flush;
   assign push_s = push & (~full | pop_s) & ~flush;

   // Pointer/count update and look-ahead of the next head entry.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
         rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
         count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
         if (count_d == {CNT_W{1'b0}}) begin
            head_d = head_q;
         end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = din;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         head_q   <= {DATA_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MCPU instruction fetch stage: owns the PC, captures the combinational RAM
// read into the prefetch FIFO and hands {word, pc} to decode.
module mcpu_fetch_unit
   import mcpu_pkg::*;
#(
   parameter int                    WORD_SIZE  = DEF_WORD_SIZE,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   halt,
   input  logic                   redirect,
   input  logic [ADDR_WIDTH-1:0]  redirect_addr,
   output logic [ADDR_WIDTH-1:0]  instraddr,
   input  logic [WORD_SIZE-1:0]   instrrd,
   mcpu_fetch_unit_if.master      dec_if,
   output logic                   fetching
);

   localparam int ENT_W = WORD_SIZE + ADDR_WIDTH;
   localparam int CNT_W = cnt_width(FIFO_DEPTH);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  fetching_q, fetching_d;
   logic                  push_s, pop_s, flush_s, room_s;
   logic                  full_s, empty_s;
   logic [CNT_W-1:0]      count_s;
   logic [ENT_W-1:0]      head_s;

   // A redirect discards the head, so decode's ready is ignored that cycle.
   assign pop_s  = ~empty_s & dec_if.instr_ready & ~redirect;
   assign room_s = ((count_s < CNT_W'(FIFO_DEPTH)) & ~full_s) | pop_s;

   // State, PC and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= {ADDR_WIDTH{1'b0}};
         fetching_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetching_q <= fetching_d;
      end
   end

   // Next-state: redirect beats halt and start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = (redirect || start) ? ST_FETCH : ST_IDLE;
         ST_FETCH:  state_d = redirect ? ST_FETCH : (halt ? ST_HALTED : ST_FETCH);
         ST_HALTED: state_d = redirect ? ST_FETCH : ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   // PC and FIFO control; PC only advances when its word is actually pushed.
   always_comb begin
      pc_d    = pc_q;
      push_s  = 1'b0;
      flush_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               pc_d    = redirect_addr;
               flush_s = 1'b1;
            end else if (start) begin
               pc_d = RESET_PC;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_FETCH: begin
            if (redirect) begin
               pc_d    = redirect_addr;
               flush_s = 1'b1;
            end else if (halt) begin
               pc_d = pc_q;
            end else if (room_s) begin
               push_s = 1'b1;
               pc_d   = pc_q + ADDR_WIDTH'(1);
            end else begin
               pc_d = pc_q;
            end
         end
         ST_HALTED: begin
            if (redirect) begin
               pc_d    = redirect_addr;
               flush_s = 1'b1;
            end else begin
               pc_d = pc_q;
            end
         end
         default: begin
            pc_d    = {ADDR_WIDTH{1'b0}};
            flush_s = 1'b1;
         end
      endcase
      fetching_d = (state_d == ST_FETCH);
   end

   mcpu_fetch_fifo #(
      .DATA_W (ENT_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .din   ({instrrd, pc_q}),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s),
      .head  (head_s)
   );

   assign instraddr          = pc_q;
   assign fetching           = fetching_q;
   assign dec_if.instr_out   = head_s[ADDR_WIDTH +: WORD_SIZE];
   assign dec_if.instr_pc    = head_s[ADDR_WIDTH-1:0];
   assign dec_if.instr_valid = ~empty_s;

endmodule
